// File: rtl/riscv_mem_pkg.sv
// Shared constants, width helpers and the response record for the harness backing memory.
// The response FIFO is typed with resp_t unless the top module passes a resized record.
package riscv_mem_pkg;

  localparam int DEF_ADDR_BITS   = 26;
  localparam int DEF_DATA_BITS   = 128;
  localparam int DEF_TAG_BITS    = 5;
  localparam int DEF_DEPTH_WORDS = 65536;
  localparam int DEF_LATENCY     = 4;
  localparam int DEF_QDEPTH      = 8;

  function automatic int mask_bits(input int data_bits);
    return data_bits / 8;
  endfunction

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index into n entries, never narrower than one bit.
  function automatic int ptr_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_DATA_BITS-1:0] data;
    logic [DEF_TAG_BITS-1:0]  tag;
  } resp_t;

endpackage

// File: rtl/riscv_mem_resp_fifo.sv
// In-order response queue holding QDEPTH records of type T.
// Pointers wrap explicitly, so QDEPTH does not have to be a power of two.
module riscv_mem_resp_fifo
  import riscv_mem_pkg::*;
#(
  parameter int  QDEPTH = DEF_QDEPTH,
  parameter type T      = resp_t
) (
  input  logic clk,
  input  logic reset,
  input  logic enq_i,
  input  T     enq_data_i,
  input  logic deq_i,
  output logic val_o,
  output T     head_o
);

  localparam int PTR_BITS = ptr_bits(QDEPTH);
  localparam int CNT_BITS = cnt_bits(QDEPTH);
  localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(QDEPTH - 1);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(QDEPTH);

  T                    store_q [QDEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                do_enq, do_deq;

  function automatic logic [PTR_BITS-1:0] wrap_inc(input logic [PTR_BITS-1:0] p);
    return (p == LAST) ? '0 : p + PTR_BITS'(1);
  endfunction

  assign val_o  = (count_q != '0);
  assign do_deq = deq_i && val_o;
  // A push into a full queue is only taken when the head leaves on the same edge.
  assign do_enq = enq_i && ((count_q != FULL) || do_deq);
  assign head_o = val_o ? store_q[rd_ptr_q] : '0;

  // NOTE: storage arrays carry no reset; only pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_enq) store_q[wr_ptr_q] <= enq_data_i;
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (do_deq) rd_ptr_q <= wrap_inc(rd_ptr_q);
      if (do_enq && !do_deq)      count_q <= count_q + CNT_BITS'(1);
      else if (!do_enq && do_deq) count_q <= count_q - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/riscv_mem_model.sv
// Cycle-accurate backing memory: byte-masked writes, fixed-latency tagged reads,
// credit-limited in-order responses with backpressure and a sticky out-of-range flag.
module riscv_mem_model
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int TAG_BITS    = DEF_TAG_BITS,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int QDEPTH      = DEF_QDEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mem_req_val,
  output logic                            mem_req_rdy,
  input  logic                            mem_req_rw,
  input  logic [ADDR_BITS-1:0]            mem_req_addr,
  input  logic [DATA_BITS-1:0]            mem_req_data,
  input  logic [mask_bits(DATA_BITS)-1:0] mem_req_wmask,
  input  logic [TAG_BITS-1:0]             mem_req_tag,
  output logic                            mem_resp_val,
  input  logic                            mem_resp_rdy,
  output logic [DATA_BITS-1:0]            mem_resp_data,
  output logic [TAG_BITS-1:0]             mem_resp_tag,
  output logic                            oob_err
);

  localparam int MASK_BITS = mask_bits(DATA_BITS);
  localparam int CNT_BITS  = cnt_bits(QDEPTH);
  localparam int IDX_BITS  = ptr_bits(DEPTH_WORDS);
  localparam int STAGES    = LATENCY - 1;
  localparam logic [ADDR_BITS:0]  DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH_WORDS);
  localparam logic [CNT_BITS-1:0] CREDITS   = CNT_BITS'(QDEPTH);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [TAG_BITS-1:0]  tag;
  } resp_w_t;

  logic [DATA_BITS-1:0] mem_q [DEPTH_WORDS];
  logic [CNT_BITS-1:0]  inflight_q, inflight_d;
  logic                 oob_q;
  logic                 req_fire, wr_fire, rd_fire, resp_pop, in_range;
  logic [IDX_BITS-1:0]  idx;
  logic                 enq, head_val;
  resp_w_t              rd_entry, enq_data, head;

  assign mem_req_rdy = !reset && (inflight_q < CREDITS);
  assign req_fire    = mem_req_val && mem_req_rdy;
  assign wr_fire     = req_fire && mem_req_rw;
  assign rd_fire     = req_fire && !mem_req_rw;
  assign in_range    = {1'b0, mem_req_addr} < DEPTH_LIM;
  assign idx         = mem_req_addr[IDX_BITS-1:0];

  assign rd_entry.data = in_range ? mem_q[idx] : '0;
  assign rd_entry.tag  = mem_req_tag;

  // Contents survive reset: the harness preloads the array before releasing reset.
  always_ff @(posedge clk) begin
    if (wr_fire && in_range) begin
      for (int b = 0; b < MASK_BITS; b++) begin
        if (mem_req_wmask[b]) mem_q[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // LATENCY-1 stages here; the queue's registered head supplies the final cycle.
  generate
    if (STAGES > 0) begin : g_pipe
      logic [STAGES-1:0] val_q;
      resp_w_t           data_q [STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          val_q <= '0;
        end else begin
          val_q[0] <= rd_fire;
          for (int s = 1; s < STAGES; s++) val_q[s] <= val_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        data_q[0] <= rd_entry;
        for (int s = 1; s < STAGES; s++) data_q[s] <= data_q[s-1];
      end

      assign enq      = val_q[STAGES-1];
      assign enq_data = data_q[STAGES-1];
    end else begin : g_direct
      assign enq      = rd_fire;
      assign enq_data = rd_entry;
    end
  endgenerate

  riscv_mem_resp_fifo #(
    .QDEPTH (QDEPTH),
    .T      (resp_w_t)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq_i      (enq),
    .enq_data_i (enq_data),
    .deq_i      (mem_resp_rdy),
    .val_o      (head_val),
    .head_o     (head)
  );

  assign mem_resp_val  = head_val;
  assign mem_resp_data = head.data;
  assign mem_resp_tag  = head.tag;
  assign resp_pop      = head_val && mem_resp_rdy;
  assign oob_err       = oob_q;

  // NOTE: the default assignment comes first so this always_comb cannot infer a latch.
  always_comb begin
    inflight_d = inflight_q;
    if (rd_fire && !resp_pop)      inflight_d = inflight_q + CNT_BITS'(1);
    else if (!rd_fire && resp_pop) inflight_d = inflight_q - CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      oob_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      oob_q      <= oob_q || (req_fire && !in_range);
    end
  end

endmodule
